// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, ROM address generation, instruction register and
// fetch counter, sequenced by a four-state IDLE/ISSUE/CAPTURE/DONE machine.
// The ROM is assumed to return data one cycle after the address is presented.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to refuse fetches from a PC with
// pc[1:0] != 0 and pulse o_misalign instead. When it is undefined, o_misalign is tied low.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_AW   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch_req,
  input  logic              i_pc_we,
  input  logic [31:0]       i_pc_next,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_plus4,
  output logic              o_fetch_valid,
  output logic              o_busy,
  output logic [31:0]       o_fetch_cnt,
  output logic              o_misalign
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] cnt_q, cnt_d;
  logic        trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        start;
  logic [31:0] fetch_pc;
  logic        misalign_q;

  // A request accepted together with a redirect fetches from the redirect target.
  assign start    = i_fetch_req && ((state_q == StIdle) || (state_q == StDone));
  assign fetch_pc = i_pc_we ? i_pc_next : pc_q;
  assign trap     = start && (fetch_pc[1:0] != 2'b00);

  // One-cycle misaligned-fetch pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= trap;
    end
  end

  assign o_misalign = misalign_q;
`else
  assign trap       = 1'b0;
  assign o_misalign = 1'b0;
`endif

  // Next-state and datapath update; a redirect in ISSUE/CAPTURE cancels the fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    cnt_d    = cnt_q;

    if (i_pc_we) begin
      pc_d = i_pc_next;
    end

    unique case (state_q)
      StIdle: begin
        if (i_fetch_req) begin
          state_d = trap ? StIdle : StIssue;
        end
      end
      StIssue: begin
        state_d = i_pc_we ? StIdle : StCapture;
      end
      StCapture: begin
        if (i_pc_we) begin
          state_d = StIdle;
        end else begin
          state_d  = StDone;
          ir_d     = i_rom_data;
          pc_out_d = pc_q;
          pc_d     = pc_q + 32'd4;
          cnt_d    = cnt_q + 32'd1;
        end
      end
      StDone: begin
        state_d = (i_fetch_req && !trap) ? StIssue : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      pc_out_q <= RESET_PC;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_rom_addr    = pc_q[ROM_AW-1:0];
  assign o_instr       = ir_q;
  assign o_pc          = pc_out_q;
  assign o_pc_plus4    = pc_out_q + 32'd4;
  assign o_fetch_valid = (state_q == StDone);
  assign o_busy        = (state_q == StIssue) || (state_q == StCapture);
  assign o_fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a registered ROM model, a PC/count model that pushes
// expected {instr, pc, pc+4, count} tuples into a scoreboard, and per-scenario tasks that
// pop and compare whenever o_fetch_valid is seen. Inputs change and outputs are sampled on
// the falling edge.
module tb_instr_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        pc_we;
  logic [31:0] pc_next;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        busy;
  logic [31:0] fetch_cnt;
  logic        misalign;

  int          checks = 0;
  int          errors = 0;
  logic [127:0] sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  instr_fetch #(
    .RESET_PC(ResetPc),
    .ROM_AW  (14)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_fetch_req  (fetch_req),
    .i_pc_we      (pc_we),
    .i_pc_next    (pc_next),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_instr      (instr),
    .o_pc         (pc),
    .o_pc_plus4   (pc_plus4),
    .o_fetch_valid(fetch_valid),
    .o_busy       (busy),
    .o_fetch_cnt  (fetch_cnt),
    .o_misalign   (misalign)
  );

  always #5 clk = ~clk;

  // ROM contents: address 0 holds addi x1,x0,1; every other word encodes its own address.
  function automatic logic [31:0] rom_word(input logic [13:0] a);
    if (a == 14'd0) return 32'h0010_0093;
    return {2'b00, a, 16'hC0DE};
  endfunction

  // One-cycle read latency ROM.
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic expect_fetch();
    m_cnt = m_cnt + 32'd1;
    sb_q.push_back({rom_word(m_pc[13:0]), m_pc, m_pc + 32'd4, m_cnt});
    m_pc = m_pc + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_req = 1'b0; pc_we = 1'b0; pc_next = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pc = ResetPc; m_cnt = '0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    // Reset wins over simultaneous fetch and redirect requests.
    rst = 1'b1; fetch_req = 1'b1; pc_we = 1'b1; pc_next = 32'h0000_1234;
    repeat (3) @(negedge clk);
    checks++;
    if ({fetch_valid, busy, misalign} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/busy/misalign=%b expected 000",
               {fetch_valid, busy, misalign});
    end
    checks++;
    if ({instr, pc, fetch_cnt} !== {32'h0, ResetPc, 32'h0}) begin
      errors++;
      $display("FAIL reset_regs: got instr=%h pc=%h cnt=%h expected 0/%h/0",
               instr, pc, fetch_cnt, ResetPc);
    end
    checks++;
    if (rom_addr !== ResetPc[13:0]) begin
      errors++;
      $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, ResetPc[13:0]);
    end
    rst = 1'b0; fetch_req = 1'b0; pc_we = 1'b0;
    m_pc = ResetPc; m_cnt = '0;
  endtask

  task automatic test_single_fetch();
    logic [127:0] exp_v;
    int n_valid = 0;
    fetch_req = 1'b1;
    expect_fetch();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (fetch_valid) begin
        n_valid++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL single_unexpected_valid: got valid at cycle %0d expected none", c);
        end else begin
          exp_v = sb_q.pop_front();
          if ({instr, pc, pc_plus4, fetch_cnt} !== exp_v) begin
            errors++;
            $display("FAIL single_fetch: got %h expected %h", {instr, pc, pc_plus4, fetch_cnt}, exp_v);
          end
        end
        checks++;
        if (c != 3) begin
          errors++; $display("FAIL single_latency: got valid at cycle %0d expected cycle 3", c);
        end
      end
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL single_busy: got %b expected 1", busy);
        end
      end
      fetch_req = 1'b0;
    end
    checks++;
    if (n_valid != 1) begin
      errors++; $display("FAIL single_pulse_count: got %0d expected 1", n_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_v;
    int n_valid = 0;
    fetch_req = 1'b1;
    expect_fetch();
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (fetch_valid) begin
        n_valid++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_valid: got valid at cycle %0d expected none", c);
        end else begin
          exp_v = sb_q.pop_front();
          if ({instr, pc, pc_plus4, fetch_cnt} !== exp_v || (c % 3) != 0) begin
            errors++;
            $display("FAIL b2b_fetch: got %h at cycle %0d expected %h at a multiple of 3",
                     {instr, pc, pc_plus4, fetch_cnt}, c, exp_v);
          end
        end
      end
      if (c == 3 || c == 6) expect_fetch();
      if (c == 7) fetch_req = 1'b0;
    end
    checks++;
    if (n_valid != 3 || fetch_cnt !== 32'd3) begin
      errors++; $display("FAIL b2b_count: got pulses=%0d cnt=%0d expected 3/3", n_valid, fetch_cnt);
    end
  endtask

  task automatic test_redirect_cancel();
    logic [127:0] exp_v;
    logic [31:0]  old_pc;
    old_pc = m_pc - 32'd4;
    fetch_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (fetch_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL redir_unexpected_valid: got valid at cycle %0d expected none", c);
        end else begin
          exp_v = sb_q.pop_front();
          if ({instr, pc, pc_plus4, fetch_cnt} !== exp_v) begin
            errors++;
            $display("FAIL redir_fetch: got %h expected %h", {instr, pc, pc_plus4, fetch_cnt}, exp_v);
          end
        end
      end
      if (c == 1) begin
        // In ISSUE: cancel with a redirect.
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL redir_busy: got %b expected 1", busy);
        end
        fetch_req = 1'b0; pc_we = 1'b1; pc_next = 32'h0000_0280;
      end else if (c == 2) begin
        checks++;
        if ({busy, rom_addr, pc, fetch_cnt} !== {1'b0, 14'h0280, old_pc, m_cnt}) begin
          errors++;
          $display("FAIL redir_cancel: got busy=%b addr=%h pc=%h cnt=%0d expected 0/0280/%h/%0d",
                   busy, rom_addr, pc, fetch_cnt, old_pc, m_cnt);
        end
        pc_we = 1'b0; fetch_req = 1'b1;
        m_pc = 32'h0000_0280;
        expect_fetch();
      end else begin
        fetch_req = 1'b0;
      end
    end
  endtask

  task automatic test_wrap();
    logic [127:0] exp_v;
    // Redirect and request together in IDLE: the fetch uses the new PC.
    pc_we = 1'b1; pc_next = 32'hFFFF_FFFC; fetch_req = 1'b1;
    m_pc = 32'hFFFF_FFFC;
    expect_fetch();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      pc_we = 1'b0; fetch_req = 1'b0;
      if (fetch_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL wrap_unexpected_valid: got valid at cycle %0d expected none", c);
        end else begin
          exp_v = sb_q.pop_front();
          if ({instr, pc, pc_plus4, fetch_cnt} !== exp_v) begin
            errors++;
            $display("FAIL wrap_fetch: got %h expected %h", {instr, pc, pc_plus4, fetch_cnt}, exp_v);
          end
        end
      end
      if (c == 4) begin
        checks++;
        if (rom_addr !== 14'h0000) begin
          errors++; $display("FAIL wrap_pc: got rom_addr=%h expected 0000", rom_addr);
        end
      end
    end
  endtask

  task automatic test_reset_in_capture();
    int n_valid = 0;
    fetch_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (fetch_valid) n_valid++;
      fetch_req = 1'b0;
      if (c == 2) begin
        rst = 1'b1;
      end else if (c == 3) begin
        checks++;
        if ({instr, pc, fetch_cnt, busy} !== {32'h0, ResetPc, 32'h0, 1'b0}) begin
          errors++;
          $display("FAIL rst_capture: got instr=%h pc=%h cnt=%0d busy=%b expected 0/%h/0/0",
                   instr, pc, fetch_cnt, busy, ResetPc);
        end
        rst = 1'b0;
        m_pc = ResetPc; m_cnt = '0;
      end
    end
    checks++;
    if (n_valid != 0) begin
      errors++; $display("FAIL rst_capture_valid: got %0d pulses expected 0", n_valid);
    end
  endtask

  task automatic test_misalign();
    logic [127:0] exp_v;
    int n_mis = 0;
    int n_valid = 0;
    pc_we = 1'b1; pc_next = 32'h0000_0002;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (misalign) n_mis++;
      if (fetch_valid) begin
        n_valid++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL mis_unexpected_valid: got valid at cycle %0d expected none", c);
        end else begin
          exp_v = sb_q.pop_front();
          if ({instr, pc, pc_plus4, fetch_cnt} !== exp_v) begin
            errors++;
            $display("FAIL mis_fetch: got %h expected %h", {instr, pc, pc_plus4, fetch_cnt}, exp_v);
          end
        end
      end
      pc_we = 1'b0;
      fetch_req = (c == 1);
      if (c == 1) begin
        m_pc = 32'h0000_0002;
`ifndef FETCH_MISALIGN_TRAP_EN
        expect_fetch();
`endif
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (c == 2) begin
        checks++;
        if ({misalign, busy} !== 2'b10) begin
          errors++; $display("FAIL mis_pulse: got misalign/busy=%b expected 10", {misalign, busy});
        end
      end
      if (c == 3) begin
        checks++;
        if ({misalign, rom_addr, fetch_cnt} !== {1'b0, 14'h0002, m_cnt}) begin
          errors++;
          $display("FAIL mis_hold: got misalign=%b addr=%h cnt=%0d expected 0/0002/%0d",
                   misalign, rom_addr, fetch_cnt, m_cnt);
        end
      end
`endif
    end
    checks++;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (n_mis != 1 || n_valid != 0) begin
      errors++; $display("FAIL mis_counts: got misalign=%0d valid=%0d expected 1/0", n_mis, n_valid);
    end
`else
    if (n_mis != 0 || n_valid != 1) begin
      errors++; $display("FAIL mis_counts: got misalign=%0d valid=%0d expected 0/1", n_mis, n_valid);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; pc_we = 1'b0; pc_next = '0;
    m_pc = ResetPc; m_cnt = '0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    do_reset();
    test_back_to_back();
    test_redirect_cancel();
    test_wrap();
    test_reset_in_capture();
    test_misalign();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
